// File: rtl/semaforo_pkg.sv
// -----------------------------------------------------------------------------
// semaforo_pkg
// Shared types and constants for the two-street traffic-light sequencer.
//   state_t    : the four phases of the controller
//   AB_*       : 2-bit codes {A_has_right_of_way, amber} sent to the decoder
//   ab_code()  : maps a phase to its AB code
// -----------------------------------------------------------------------------
package semaforo_pkg;

   typedef enum logic [1:0] {
      GREEN_A = 2'd0,
      AMBER_A = 2'd1,
      GREEN_B = 2'd2,
      AMBER_B = 2'd3
   } state_t;

   localparam logic [1:0] AB_A_GREEN = 2'b10;
   localparam logic [1:0] AB_A_AMBER = 2'b11;
   localparam logic [1:0] AB_B_GREEN = 2'b00;
   localparam logic [1:0] AB_B_AMBER = 2'b01;

   // Any unexpected phase value falls back to the A-green code.
   function automatic logic [1:0] ab_code(input state_t s);
      logic [1:0] code;
      case (s)
         GREEN_A: code = AB_A_GREEN;
         AMBER_A: code = AB_A_AMBER;
         GREEN_B: code = AB_B_GREEN;
         AMBER_B: code = AB_B_AMBER;
         default: code = AB_A_GREEN;
      endcase
      return code;
   endfunction

endpackage

// File: rtl/sync_2ff.sv
// -----------------------------------------------------------------------------
// sync_2ff
// Single-bit two-flop synchronizer for an asynchronous level input.
//   clk_i  : destination clock, rising edge
//   rst_ni : asynchronous active-low reset, clears both flops
//   d_i    : asynchronous input
//   q_o    : synchronized output (two clock edges of latency)
// -----------------------------------------------------------------------------
module sync_2ff (
   input  logic clk_i,
   input  logic rst_ni,
   input  logic d_i,
   output logic q_o
);

   logic meta_q;
   logic sync_q;

   // Two-stage shift register; meta_q may go metastable, sync_q is the clean copy.
   always_ff @(posedge clk_i or negedge rst_ni) begin
      if (!rst_ni) begin
         meta_q <= 1'b0;
         sync_q <= 1'b0;
      end else begin
         meta_q <= d_i;
         sync_q <= meta_q;
      end
   end

   assign q_o = sync_q;

endmodule

// File: rtl/semaforo_sequenciador.sv
// -----------------------------------------------------------------------------
// semaforo_sequenciador
// Decides right-of-way between streets A and B from car-presence sensors,
// using minimum/maximum green and fixed amber timing, and drives the AB code
// for the light decoder plus the two amber lamps.
//   clk      : system clock, rising edge
//   rst_n    : asynchronous active-low reset (rests on A green)
//   sensor_a : car present on street A (asynchronous level)
//   sensor_b : car present on street B (asynchronous level)
//   ab       : {A_has_right_of_way, amber} to the decoder (registered)
//   amber_a  : amber lamp, street A (registered)
//   amber_b  : amber lamp, street B (registered)
// -----------------------------------------------------------------------------
module semaforo_sequenciador
   import semaforo_pkg::*;
#(
   parameter int unsigned MIN_GREEN  = 4,
   parameter int unsigned MAX_GREEN  = 10,
   parameter int unsigned AMBER_TIME = 2,
   parameter int unsigned CNT_W      = 8
) (
   input  logic       clk,
   input  logic       rst_n,
   input  logic       sensor_a,
   input  logic       sensor_b,
   output logic [1:0] ab,
   output logic       amber_a,
   output logic       amber_b
);

   // Timer thresholds: the timer counts 0..N-1 across an N-cycle phase.
   localparam logic [CNT_W-1:0] MIN_T = CNT_W'(MIN_GREEN - 1);
   localparam logic [CNT_W-1:0] MAX_T = CNT_W'(MAX_GREEN - 1);
   localparam logic [CNT_W-1:0] AMB_T = CNT_W'(AMBER_TIME - 1);
   localparam logic [CNT_W-1:0] T_SAT = {CNT_W{1'b1}};
   localparam logic [CNT_W-1:0] T_ONE = CNT_W'(1);

   logic             sa_s;
   logic             sb_s;
   state_t           state_q,   state_d;
   logic [CNT_W-1:0] timer_q,   timer_d;
   logic             req_a_q,   req_a_d;
   logic             req_b_q,   req_b_d;
   logic [1:0]       ab_q,      ab_d;
   logic             amber_a_q, amber_a_d;
   logic             amber_b_q, amber_b_d;
   logic             enter_green_a_s;
   logic             enter_green_b_s;

   sync_2ff u_sync_a (
      .clk_i  (clk),
      .rst_ni (rst_n),
      .d_i    (sensor_a),
      .q_o    (sa_s)
   );

   sync_2ff u_sync_b (
      .clk_i  (clk),
      .rst_ni (rst_n),
      .d_i    (sensor_b),
      .q_o    (sb_s)
   );

   // Next-phase decision. A green phase ends only when the other street is
   // waiting: early (gap-out) once minimum green has elapsed and the own
   // street is empty, or unconditionally at maximum green (max-out).
   always_comb begin
      state_d = GREEN_A;
      case (state_q)
         GREEN_A: begin
            if (req_b_q && (((timer_q >= MIN_T) && !sa_s) || (timer_q >= MAX_T))) begin
               state_d = AMBER_A;
            end else begin
               state_d = GREEN_A;
            end
         end
         AMBER_A: begin
            if (timer_q == AMB_T) begin
               state_d = GREEN_B;
            end else begin
               state_d = AMBER_A;
            end
         end
         GREEN_B: begin
            if (req_a_q && (((timer_q >= MIN_T) && !sb_s) || (timer_q >= MAX_T))) begin
               state_d = AMBER_B;
            end else begin
               state_d = GREEN_B;
            end
         end
         AMBER_B: begin
            if (timer_q == AMB_T) begin
               state_d = GREEN_A;
            end else begin
               state_d = AMBER_B;
            end
         end
         default: state_d = GREEN_A;
      endcase
   end

   // Phase timer: restarts on every transition, otherwise counts and saturates.
   always_comb begin
      timer_d = timer_q;
      if (state_d != state_q) begin
         timer_d = '0;
      end else if (timer_q == T_SAT) begin
         timer_d = timer_q;
      end else begin
         timer_d = timer_q + T_ONE;
      end
   end

   assign enter_green_a_s = (state_d == GREEN_A) && (state_q != GREEN_A);
   assign enter_green_b_s = (state_d == GREEN_B) && (state_q != GREEN_B);

   // Request latches: a street registers demand only while it is not green;
   // granting its green clears the request, taking priority over a new set.
   always_comb begin
      req_a_d = req_a_q;
      req_b_d = req_b_q;
      if (enter_green_a_s) begin
         req_a_d = 1'b0;
      end else begin
         req_a_d = req_a_q | (sa_s & (state_q != GREEN_A));
      end
      if (enter_green_b_s) begin
         req_b_d = 1'b0;
      end else begin
         req_b_d = req_b_q | (sb_s & (state_q != GREEN_B));
      end
   end

   // Moore outputs decoded from the next phase so they register alongside it.
   always_comb begin
      ab_d      = ab_code(state_d);
      amber_a_d = (state_d == AMBER_A);
      amber_b_d = (state_d == AMBER_B);
   end

   // State, timer, requests and outputs; reset rests on A green with no demand.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q   <= GREEN_A;
         timer_q   <= '0;
         req_a_q   <= 1'b0;
         req_b_q   <= 1'b0;
         ab_q      <= AB_A_GREEN;
         amber_a_q <= 1'b0;
         amber_b_q <= 1'b0;
      end else begin
         state_q   <= state_d;
         timer_q   <= timer_d;
         req_a_q   <= req_a_d;
         req_b_q   <= req_b_d;
         ab_q      <= ab_d;
         amber_a_q <= amber_a_d;
         amber_b_q <= amber_b_d;
      end
   end

   assign ab      = ab_q;
   assign amber_a = amber_a_q;
   assign amber_b = amber_b_q;

endmodule

// File: tb/tb_semaforo_sequenciador.sv
// -----------------------------------------------------------------------------
// tb_semaforo_sequenciador
// Directed scenarios with hand-derived per-cycle expectations. The stimulus
// process pushes the expected {ab, amber_a, amber_b} for each clock edge into
// a queue; the monitor pops and compares on the following falling edge, or
// immediately on chk_ev for asynchronous-reset checks.
// -----------------------------------------------------------------------------
module tb_semaforo_sequenciador;

   logic       clk = 1'b0;
   logic       rst_n;
   logic       sensor_a;
   logic       sensor_b;
   logic [1:0] ab;
   logic       amber_a;
   logic       amber_b;

   logic [3:0] exp_q[$];
   string      tag_q[$];
   int         checks   = 0;
   int         failures = 0;
   event       chk_ev;

   semaforo_sequenciador #(
      .MIN_GREEN  (4),
      .MAX_GREEN  (10),
      .AMBER_TIME (2),
      .CNT_W      (8)
   ) dut (
      .clk      (clk),
      .rst_n    (rst_n),
      .sensor_a (sensor_a),
      .sensor_b (sensor_b),
      .ab       (ab),
      .amber_a  (amber_a),
      .amber_b  (amber_b)
   );

   always #5 clk = ~clk;

   // Expected lamps follow the Moore table: amber_a only in 11, amber_b only in 01.
   task automatic push_exp(input logic [1:0] e_ab, input string tag);
      logic [3:0] v;
      v = {e_ab, (e_ab == 2'b11), (e_ab == 2'b01)};
      exp_q.push_back(v);
      tag_q.push_back(tag);
   endtask

   // Drive sensors, then for n edges push the expected post-edge outputs.
   task automatic run(input logic sa, input logic sb, input logic [1:0] e_ab,
                      input int n, input string tag);
      sensor_a = sa;
      sensor_b = sb;
      for (int i = 0; i < n; i++) begin
         @(posedge clk);
         #1;
         push_exp(e_ab, tag);
      end
   endtask

   // Assert reset away from an edge, check the outputs respond asynchronously,
   // hold for two edges and release just after a rising edge.
   task automatic do_reset(input logic sa, input logic sb, input string tag);
      @(negedge clk);
      #1;
      rst_n    = 1'b0;
      sensor_a = sa;
      sensor_b = sb;
      #1;
      push_exp(2'b10, {tag, "_async_rst"});
      -> chk_ev;
      run(sa, sb, 2'b10, 2, {tag, "_in_rst"});
      rst_n = 1'b1;
   endtask

   // Monitor: compares every queued expectation against the live outputs.
   initial begin
      logic [3:0] e;
      string      t;
      forever begin
         @(negedge clk or chk_ev);
         while (exp_q.size() > 0) begin
            e = exp_q.pop_front();
            t = tag_q.pop_front();
            checks++;
            if ({ab, amber_a, amber_b} !== e) begin
               failures++;
               $display("FAIL %s @%0t: got ab=%b amber_a=%b amber_b=%b, expected ab=%b amber_a=%b amber_b=%b",
                        t, $time, ab, amber_a, amber_b, e[3:2], e[1], e[0]);
            end
         end
      end
   end

   // Watchdog: the scenario is a few hundred cycles long.
   initial begin
      #200000;
      $display("FAIL watchdog: simulation did not finish in time");
      $fatal(1, "watchdog expired");
   end

   initial begin
      rst_n    = 1'b0;
      sensor_a = 1'b0;
      sensor_b = 1'b0;

      // 1. No traffic: rests on A for 50 cycles.
      do_reset(1'b0, 1'b0, "idle");
      run(1'b0, 1'b0, 2'b10, 50, "idle_rest_a");

      // 2. One-cycle B pulse after edge 10: request latched at edge 13,
      //    gap-out to amber at edge 14, two amber cycles, then B rests green.
      do_reset(1'b0, 1'b0, "pulse");
      run(1'b0, 1'b0, 2'b10, 10, "pulse_pre");
      run(1'b0, 1'b1, 2'b10, 1,  "pulse_hi");
      run(1'b0, 1'b0, 2'b10, 2,  "pulse_sync");
      run(1'b0, 1'b0, 2'b11, 2,  "pulse_amber_a");
      run(1'b0, 1'b0, 2'b00, 10, "pulse_rest_b");

      // 3. Both sensors held: 10/11/00/01 phases of 10/2/10/2 cycles repeat.
      //    The first A green includes the cycle right after release.
      do_reset(1'b1, 1'b1, "both");
      run(1'b1, 1'b1, 2'b10, 9, "both_green_a0");
      for (int k = 0; k < 2; k++) begin
         run(1'b1, 1'b1, 2'b11, 2,  "both_amber_a");
         run(1'b1, 1'b1, 2'b00, 10, "both_green_b");
         run(1'b1, 1'b1, 2'b01, 2,  "both_amber_b");
         run(1'b1, 1'b1, 2'b10, 10, "both_green_a");
      end

      // 4. A held busy, B raised at release: A max-outs after 10 cycles.
      //    B then empties: B green gaps out at minimum green (4 cycles),
      //    amber B, then A rests green.
      do_reset(1'b1, 1'b1, "maxout");
      run(1'b1, 1'b1, 2'b10, 9,  "maxout_green_a");
      run(1'b1, 1'b1, 2'b11, 2,  "maxout_amber_a");
      run(1'b1, 1'b1, 2'b00, 1,  "gapout_green_b0");
      run(1'b1, 1'b0, 2'b00, 3,  "gapout_green_b");
      run(1'b1, 1'b0, 2'b01, 2,  "gapout_amber_b");
      run(1'b1, 1'b0, 2'b10, 15, "gapout_rest_a");

      // 5. Reset in the middle of amber A: immediate A green, request dropped.
      do_reset(1'b0, 1'b1, "amb_rst");
      run(1'b0, 1'b1, 2'b10, 3, "amb_rst_green_a");
      run(1'b0, 1'b1, 2'b11, 1, "amb_rst_amber_a");
      do_reset(1'b0, 1'b0, "amb_rst_mid");
      run(1'b0, 1'b0, 2'b10, 20, "amb_rst_rest_a");

      // 6. B glitch entirely between two rising edges: never sampled.
      do_reset(1'b0, 1'b0, "glitch");
      run(1'b0, 1'b0, 2'b10, 5, "glitch_pre");
      sensor_b = 1'b1;
      #3;
      sensor_b = 1'b0;
      run(1'b0, 1'b0, 2'b10, 20, "glitch_rest_a");

      // Drain and make sure every expectation was consumed.
      @(negedge clk);
      #1;
      checks++;
      if (exp_q.size() != 0) begin
         failures++;
         $display("FAIL drain: %0d expectations left, expected 0", exp_q.size());
      end

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
